fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- IF stage of the 5-stage RV32 pipeline, directly upstream of the fetch/decode pipeline register.
- Owns the PC and issues one instruction-memory request at a time over a req/ack handshake.
- Buffers the returned word and presents InstrF/PCPlus4F to the fetch/decode register.
- Handles stalls from the hazard unit and branch/jump redirects from EX, including discarding a stale in-flight fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, word driven on InstrF when no valid instruction is buffered (addi x0,x0,0).
- TIMEOUT_CYC, 16, cycles without ack before retry; used only with FETCH_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- StallF  in  1  hazard unit hold; the buffered instruction is not consumed.
- RedirectF  in  1  one-cycle pulse: taken branch/jump resolved in EX.
- PCTargetE  in  32  redirect target.
- imem_req  out  1  fetch request, registered.
- imem_addr  out  32  request address, registered, word aligned.
- imem_ack  in  1  request complete; imem_rdata valid this cycle.
- imem_rdata  in  32  instruction word.
- InstrF  out  32  instruction to the fetch/decode register.
- PCPlus4F  out  32  PC+4 of InstrF.
- PCF  out  32  current PC register.
- FetchEmpty  out  1  1 when no valid instruction is buffered (bubble).
- FetchErr  out  1  sticky timeout flag.

Behaviour:
- States: BOOT, FETCH, FULL, DROP, RETRY (RETRY only with the macro).
- Reset (async, reset=0) sets:
  - state=BOOT, PCF=RESET_PC, ibuf_valid=0
  - imem_req=0, imem_addr=RESET_PC
  - InstrF=NOP_INSTR, PCPlus4F=0, FetchEmpty=1, FetchErr=0.
- BOOT: lasts one cycle with no request. Then goes to FETCH with imem_req=1 and imem_addr=PCF.
- FETCH:
  - imem_req is held at 1 and imem_addr is held stable until imem_ack is sampled 1.
  - On ack: ibuf<=imem_rdata, ibuf_valid<=1, imem_req<=0, go to FULL.
  - Minimum latency: ack in the first request cycle puts the instruction on InstrF one cycle later.
- FULL:
  - Outputs: InstrF=ibuf, PCPlus4F=PCF+4, FetchEmpty=0.
  - An edge with StallF=0 consumes the instruction: PCF<=PCF+4, ibuf_valid<=0, start a request at the new PCF, go to FETCH.
  - StallF=1: hold all state and outputs.
- Empty outputs: when ibuf_valid=0, InstrF=NOP_INSTR, PCPlus4F=0, FetchEmpty=1.
- Redirect handling:
  - RedirectF=1 takes priority over StallF in every state. It sets PCF<=PCTargetE with bits [1:0] forced to 0, and ibuf_valid<=0.
  - From BOOT or FULL: go to FETCH with the request at the new PCF.
  - From FETCH, ack on the same edge: the returned word is discarded and the new request is issued next cycle (FETCH).
  - From FETCH, no ack: go to DROP; imem_req stays 1 and imem_addr stays at the old address.
  - From DROP: PCF is updated again; stay in DROP.
- DROP: keep the old request until ack. On ack: discard imem_rdata and issue at PCF (FETCH). Nothing is ever presented from a dropped request.
- Arithmetic: PC+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
- Outstanding requests: at most one at any time.
- Reset mid-request: imem_req drops immediately; the memory must tolerate request abandonment.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- With the macro:
  - A counter runs while imem_req=1 and ack=0, and clears on ack, redirect or reset.
  - When the counter reaches TIMEOUT_CYC: imem_req<=0 for one cycle (RETRY), FetchErr<=1 (sticky until reset), then re-issue at PCF (FETCH).
  - DROP times out the same way and re-issues at PCF.
- Without the macro: the unit waits for ack indefinitely and FetchErr is tied to 0.

Test Plan:
- Reset release with RESET_PC=0 and ack 1 cycle after req -> imem_addr sequence 0,4,8. InstrF shows each imem_rdata for one cycle, alternating with NOP_INSTR (FetchEmpty=1); PCPlus4F=4,8,12.
- StallF=1 for 3 cycles while in FULL with InstrF=32'h00500093 -> InstrF, PCF and imem_req held for all 3 cycles; resumes at PCF+4 after release.
- Redirect with PCTargetE=32'h0000_0103 while in FETCH with ack delayed 4 cycles -> the old-address ack is discarded, next imem_addr=32'h0000_0100, and no stale word ever appears on InstrF.
- RedirectF and StallF both 1 in FULL -> redirect wins: FetchEmpty=1 and the next request is at the target.
- PCF=32'hFFFF_FFFC consumed -> next imem_addr=0.
- FETCH_TIMEOUT_EN with TIMEOUT_CYC=16 and no ack -> imem_req low for one cycle after 16 cycles, FetchErr=1 and stays 1, same address re-issued.

Source files
------------

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit -- IF stage of the 5-stage RV32 pipeline.
//
// Owns the PC, issues at most one instruction-memory request at a time over a
// req/ack handshake, buffers the returned word and presents it (with PC+4) to
// the fetch/decode register. Handles hazard-unit stalls and EX redirects,
// discarding a fetch that was already in flight when a redirect arrives.
//
// Optional feature (macro FETCH_TIMEOUT_EN): a request that sees no ack for
// TIMEOUT_CYC cycles is withdrawn for one cycle (RETRY), the sticky FetchErr
// flag is set, and the fetch is re-issued at PCF. Without the macro the unit
// waits for ack indefinitely and FetchErr is tied low.
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   asynchronous active-low reset
//   StallF       in   hold the buffered instruction (not consumed)
//   RedirectF    in   one-cycle redirect pulse from EX
//   PCTargetE    in   redirect target (bits [1:0] ignored)
//   imem_req     out  fetch request (registered)
//   imem_addr    out  fetch address (registered, word aligned)
//   imem_ack     in   request complete, imem_rdata valid
//   imem_rdata   in   returned instruction word
//   InstrF       out  instruction to fetch/decode register (NOP when empty)
//   PCPlus4F     out  PC+4 of InstrF (0 when empty)
//   PCF          out  current PC register
//   FetchEmpty   out  no valid instruction buffered
//   FetchErr     out  sticky fetch-timeout flag
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        RedirectF,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrF,
  output logic [31:0] PCPlus4F,
  output logic [31:0] PCF,
  output logic        FetchEmpty,
  output logic        FetchErr
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_FETCH = 3'd1,
    S_FULL  = 3'd2,
    S_DROP  = 3'd3
`ifdef FETCH_TIMEOUT_EN
    ,
    S_RETRY = 3'd4
`endif
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [XLEN-1:0] pc_nxt;
  logic [XLEN-1:0] addr_nxt;
  logic [XLEN-1:0] instr_nxt;
  logic [XLEN-1:0] pcp4_nxt;
  logic            req_nxt;
  logic            empty_nxt;

  // Word-aligned redirect target, PC+4 (wraps mod 2^32) and the PC a fresh
  // request should use this edge (redirect target wins over the held PC).
  logic [XLEN-1:0] redir_pc;
  logic [XLEN-1:0] pc_inc;
  logic [XLEN-1:0] reissue_pc;

  assign redir_pc   = PCTargetE & ~XLEN'(3);
  assign pc_inc     = PCF + XLEN'(4);
  assign reissue_pc = RedirectF ? redir_pc : PCF;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] tmo_cnt;
  logic [CNT_W-1:0] tmo_cnt_nxt;
  logic             tmo_hit;
  logic             err_nxt;

  // Fires on the edge that completes TIMEOUT_CYC unacknowledged request
  // cycles; an ack or redirect on that edge takes precedence.
  assign tmo_hit = imem_req && !imem_ack && !RedirectF &&
                   ((tmo_cnt + CNT_W'(1)) == CNT_W'(TIMEOUT_CYC));

  // Counts request cycles without ack; cleared by ack, redirect or timeout.
  always_comb begin
    tmo_cnt_nxt = '0;
    if (imem_req && !imem_ack && !RedirectF && !tmo_hit) begin
      tmo_cnt_nxt = tmo_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt  <= '0;
      FetchErr <= 1'b0;
    end else begin
      tmo_cnt  <= tmo_cnt_nxt;
      FetchErr <= err_nxt;
    end
  end
`else
  assign FetchErr = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; redirect outranks stall in every state.
  always_comb begin
    state_nxt = state;
    case (state)
      S_BOOT: begin
        state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (RedirectF) begin
          // Ack on the redirect edge is simply discarded; otherwise the old
          // request must still be drained before re-issuing.
          state_nxt = imem_ack ? S_FETCH : S_DROP;
        end else if (imem_ack) begin
          state_nxt = S_FULL;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (tmo_hit) begin
          state_nxt = S_RETRY;
        end
`endif
      end
      S_FULL: begin
        if (RedirectF || !StallF) begin
          state_nxt = S_FETCH;
        end
      end
      S_DROP: begin
        if (imem_ack) begin
          state_nxt = S_FETCH;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (tmo_hit) begin
          state_nxt = S_RETRY;
        end
`endif
      end
`ifdef FETCH_TIMEOUT_EN
      S_RETRY: begin
        state_nxt = S_FETCH;
      end
`endif
      default: begin
        state_nxt = S_BOOT;
      end
    endcase
  end

  // Output / datapath next values for PC, request and instruction buffer.
  always_comb begin
    pc_nxt    = PCF;
    req_nxt   = imem_req;
    addr_nxt  = imem_addr;
    instr_nxt = InstrF;
    pcp4_nxt  = PCPlus4F;
    empty_nxt = FetchEmpty;
`ifdef FETCH_TIMEOUT_EN
    err_nxt   = FetchErr;
`endif

    // Any redirect updates the PC and empties the buffer.
    if (RedirectF) begin
      pc_nxt    = redir_pc;
      instr_nxt = NOP_INSTR;
      pcp4_nxt  = '0;
      empty_nxt = 1'b1;
    end

    case (state)
      S_BOOT: begin
        req_nxt  = 1'b1;
        addr_nxt = reissue_pc;
      end
      S_FETCH: begin
        if (RedirectF) begin
          if (imem_ack) begin
            req_nxt  = 1'b1;
            addr_nxt = redir_pc;
          end
        end else if (imem_ack) begin
          req_nxt   = 1'b0;
          instr_nxt = imem_rdata;
          pcp4_nxt  = pc_inc;
          empty_nxt = 1'b0;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (tmo_hit) begin
          req_nxt = 1'b0;
          err_nxt = 1'b1;
        end
`endif
      end
      S_FULL: begin
        if (RedirectF) begin
          req_nxt  = 1'b1;
          addr_nxt = redir_pc;
        end else if (!StallF) begin
          pc_nxt    = pc_inc;
          instr_nxt = NOP_INSTR;
          pcp4_nxt  = '0;
          empty_nxt = 1'b1;
          req_nxt   = 1'b1;
          addr_nxt  = pc_inc;
        end
      end
      S_DROP: begin
        // The old request stays on the bus until acked; its data is dropped.
        if (imem_ack) begin
          req_nxt  = 1'b1;
          addr_nxt = reissue_pc;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (tmo_hit) begin
          req_nxt = 1'b0;
          err_nxt = 1'b1;
        end
`endif
      end
`ifdef FETCH_TIMEOUT_EN
      S_RETRY: begin
        req_nxt  = 1'b1;
        addr_nxt = reissue_pc;
      end
`endif
      default: begin
        req_nxt = 1'b0;
      end
    endcase
  end

  // PC, request and instruction-buffer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PCF        <= RESET_PC;
      imem_req   <= 1'b0;
      imem_addr  <= RESET_PC;
      InstrF     <= NOP_INSTR;
      PCPlus4F   <= '0;
      FetchEmpty <= 1'b1;
    end else begin
      PCF        <= pc_nxt;
      imem_req   <= req_nxt;
      imem_addr  <= addr_nxt;
      InstrF     <= instr_nxt;
      PCPlus4F   <= pcp4_nxt;
      FetchEmpty <= empty_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        StallF;
  logic        RedirectF;
  logic [31:0] PCTargetE;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] InstrF;
  logic [31:0] PCPlus4F;
  logic [31:0] PCF;
  logic        FetchEmpty;
  logic        FetchErr;

  fetch_unit dut (
    .clk        (clk),
    .reset      (reset),
    .StallF     (StallF),
    .RedirectF  (RedirectF),
    .PCTargetE  (PCTargetE),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .InstrF     (InstrF),
    .PCPlus4F   (PCPlus4F),
    .PCF        (PCF),
    .FetchEmpty (FetchEmpty),
    .FetchErr   (FetchErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcp4;
  } pres_t;

  logic [31:0] req_q[$];
  pres_t       pres_q[$];

  int checks   = 0;
  int errors   = 0;
  int pres_cnt = 0;

  bit mon_en    = 1'b0;
  bit mem_on    = 1'b0;
  int ack_delay = 0;
  int wait_cnt  = 0;

  logic        prev_req   = 1'b0;
  logic [31:0] prev_addr  = 32'h0;
  logic        prev_empty = 1'b1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_000C) return 32'h0050_0093;
    return a ^ 32'h5A5A_0003;
  endfunction

  function automatic pres_t mk_pres(input logic [31:0] a);
    pres_t p;
    p.instr = mem_word(a);
    p.pcp4  = a + 32'd4;
    return p;
  endfunction

  // Memory responder: acks after ack_delay waiting cycles, one-cycle ack.
  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      imem_ack = 1'b0;
      wait_cnt = 0;
    end else if (imem_ack) begin
      imem_ack = 1'b0;
      wait_cnt = 0;
    end else if (imem_req && mem_on) begin
      if (wait_cnt >= ack_delay) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
      end else begin
        wait_cnt++;
      end
    end else if (!imem_req) begin
      wait_cnt = 0;
    end
  end

  // Scoreboard monitor: new requests and new presentations pop expectations.
  always @(posedge clk) begin
    pres_t p;
    logic [31:0] ea;
    #1;
    if (mon_en) begin
      if (imem_req && (!prev_req || imem_ack)) begin
        checks++;
        if (req_q.size() == 0) begin
          errors++;
          $display("FAIL req_unexpected: imem_addr=%h, no request expected", imem_addr);
        end else begin
          ea = req_q.pop_front();
          if (imem_addr !== ea) begin
            errors++;
            $display("FAIL req_addr: imem_addr=%h required %h", imem_addr, ea);
          end
        end
      end else if (imem_req && prev_req) begin
        checks++;
        if (imem_addr !== prev_addr) begin
          errors++;
          $display("FAIL req_addr_stable: imem_addr=%h required %h", imem_addr, prev_addr);
        end
      end
      if (FetchEmpty === 1'b0 && prev_empty) begin
        pres_cnt++;
        checks++;
        if (pres_q.size() == 0) begin
          errors++;
          $display("FAIL pres_unexpected: InstrF=%h PCF=%h, nothing expected", InstrF, PCF);
        end else begin
          p = pres_q.pop_front();
          if (InstrF !== p.instr || PCPlus4F !== p.pcp4 || PCF !== (p.pcp4 - 32'd4)) begin
            errors++;
            $display("FAIL pres_data: InstrF=%h PCPlus4F=%h PCF=%h required %h %h %h",
                     InstrF, PCPlus4F, PCF, p.instr, p.pcp4, p.pcp4 - 32'd4);
          end
        end
      end
      if (FetchEmpty === 1'b1) begin
        checks++;
        if (InstrF !== NOP || PCPlus4F !== 32'h0) begin
          errors++;
          $display("FAIL empty_outputs: InstrF=%h PCPlus4F=%h required %h 0", InstrF, PCPlus4F, NOP);
        end
      end
    end
    prev_req   = imem_req;
    prev_addr  = imem_addr;
    prev_empty = FetchEmpty;
  end

  // Lets the unit run until the presentation count reaches target, then stalls.
  task automatic wait_pres(input int target, input bit rnd, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (pres_cnt >= target) begin
        ok = 1'b1;
        break;
      end
      if (rnd) StallF = 1'($urandom_range(0, 1));
    end
    StallF = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b0; StallF = 1'b1; RedirectF = 1'b0; PCTargetE = 32'h0; mem_on = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({imem_req, imem_addr, InstrF, PCPlus4F, PCF, FetchEmpty, FetchErr} !==
        {1'b0, 32'h0, NOP, 32'h0, 32'h0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: req=%b addr=%h InstrF=%h PCPlus4F=%h PCF=%h empty=%b err=%b",
               imem_req, imem_addr, InstrF, PCPlus4F, PCF, FetchEmpty, FetchErr);
    end
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL boot_request: req=%b addr=%h required 1 00000000", imem_req, imem_addr);
    end
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || FetchEmpty !== 1'b1 || PCF !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset: req=%b empty=%b PCF=%h required 0 1 00000000", imem_req, FetchEmpty, PCF);
    end
  endtask

  task automatic test_sequential;
    bit ok;
    int target;
    for (int k = 0; k < 3; k++) begin
      req_q.push_back(32'(4 * k));
      pres_q.push_back(mk_pres(32'(4 * k)));
    end
    target = pres_cnt + 3;
    ack_delay = 0; mem_on = 1'b1; StallF = 1'b0; mon_en = 1'b1;
    @(negedge clk) reset = 1'b1;
    wait_pres(target, 1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL seq_timeout: presented=%0d required %0d", pres_cnt, target); end
    checks++;
    if (req_q.size() != 0 || pres_q.size() != 0 || PCF !== 32'h8 || InstrF !== mem_word(32'h8)) begin
      errors++;
      $display("FAIL seq_end: PCF=%h InstrF=%h left=%0d/%0d required 00000008 %h 0/0",
               PCF, InstrF, req_q.size(), pres_q.size(), mem_word(32'h8));
    end
  endtask

  task automatic test_stall;
    bit ok;
    req_q.push_back(32'hC);
    pres_q.push_back(mk_pres(32'hC));
    StallF = 1'b0;
    wait_pres(pres_cnt + 1, 1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_fill_timeout: presented=%0d", pres_cnt); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (InstrF !== 32'h0050_0093 || PCF !== 32'hC || imem_req !== 1'b0 || FetchEmpty !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: InstrF=%h PCF=%h req=%b empty=%b required 00500093 0000000c 0 0",
                 i, InstrF, PCF, imem_req, FetchEmpty);
      end
    end
    req_q.push_back(32'h10);
    pres_q.push_back(mk_pres(32'h10));
    @(negedge clk) StallF = 1'b0;
    wait_pres(pres_cnt + 1, 1'b0, ok);
    checks++;
    if (!ok || PCF !== 32'h10 || req_q.size() != 0 || pres_q.size() != 0) begin
      errors++;
      $display("FAIL stall_resume: ok=%b PCF=%h required 1 00000010", ok, PCF);
    end
  endtask

  task automatic test_redirect_fetch;
    bit ok;
    int target;
    ack_delay = 4;
    req_q.push_back(32'h14);
    req_q.push_back(32'h100);
    pres_q.push_back(mk_pres(32'h100));
    target = pres_cnt + 1;
    StallF = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h14) begin
      errors++;
      $display("FAIL redir_consume: req=%b addr=%h required 1 00000014", imem_req, imem_addr);
    end
    @(negedge clk) StallF = 1'b1;
    @(negedge clk);
    RedirectF = 1'b1; PCTargetE = 32'h0000_0103;
    @(posedge clk); #1;
    checks++;
    if (PCF !== 32'h100 || imem_req !== 1'b1 || imem_addr !== 32'h14 || FetchEmpty !== 1'b1) begin
      errors++;
      $display("FAIL redir_drop: PCF=%h req=%b addr=%h empty=%b required 00000100 1 00000014 1",
               PCF, imem_req, imem_addr, FetchEmpty);
    end
    @(negedge clk) RedirectF = 1'b0;
    wait_pres(target, 1'b0, ok);
    checks++;
    if (!ok || PCF !== 32'h100 || req_q.size() != 0 || pres_q.size() != 0) begin
      errors++;
      $display("FAIL redir_end: ok=%b PCF=%h left=%0d/%0d required 1 00000100 0/0",
               ok, PCF, req_q.size(), pres_q.size());
    end
  endtask

  task automatic test_redirect_stall;
    bit ok;
    int target;
    ack_delay = 0;
    req_q.push_back(32'h200);
    pres_q.push_back(mk_pres(32'h200));
    target = pres_cnt + 1;
    RedirectF = 1'b1; PCTargetE = 32'h0000_0200;
    @(posedge clk); #1;
    checks++;
    if (FetchEmpty !== 1'b1 || InstrF !== NOP || PCF !== 32'h200 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      errors++;
      $display("FAIL redir_over_stall: empty=%b InstrF=%h PCF=%h req=%b addr=%h required 1 %h 00000200 1 00000200",
               FetchEmpty, InstrF, PCF, imem_req, imem_addr, NOP);
    end
    @(negedge clk) RedirectF = 1'b0;
    wait_pres(target, 1'b0, ok);
    checks++;
    if (!ok || req_q.size() != 0 || pres_q.size() != 0) begin
      errors++;
      $display("FAIL redir_stall_end: ok=%b left=%0d/%0d required 1 0/0", ok, req_q.size(), pres_q.size());
    end
  endtask

  task automatic test_wrap;
    bit ok;
    req_q.push_back(32'hFFFF_FFFC);
    pres_q.push_back(mk_pres(32'hFFFF_FFFC));
    RedirectF = 1'b1; PCTargetE = 32'hFFFF_FFFE;
    @(negedge clk) RedirectF = 1'b0;
    wait_pres(pres_cnt + 1, 1'b0, ok);
    checks++;
    if (!ok || PCPlus4F !== 32'h0 || FetchEmpty !== 1'b0 || PCF !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_top: ok=%b PCPlus4F=%h empty=%b PCF=%h required 1 00000000 0 fffffffc",
               ok, PCPlus4F, FetchEmpty, PCF);
    end
    req_q.push_back(32'h0);
    pres_q.push_back(mk_pres(32'h0));
    StallF = 1'b0;
    wait_pres(pres_cnt + 1, 1'b0, ok);
    checks++;
    if (!ok || PCF !== 32'h0 || PCPlus4F !== 32'h4 || req_q.size() != 0 || pres_q.size() != 0) begin
      errors++;
      $display("FAIL wrap_next: ok=%b PCF=%h PCPlus4F=%h required 1 00000000 00000004", ok, PCF, PCPlus4F);
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int target;
    ack_delay = int'($urandom_range(0, 2));
    for (int k = 1; k <= 6; k++) begin
      req_q.push_back(32'(4 * k));
      pres_q.push_back(mk_pres(32'(4 * k)));
    end
    target = pres_cnt + 6;
    StallF = 1'b0;
    wait_pres(target, 1'b1, ok);
    checks++;
    if (!ok || PCF !== 32'h18 || req_q.size() != 0 || pres_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_end: ok=%b PCF=%h left=%0d/%0d required 1 00000018 0/0",
               ok, PCF, req_q.size(), pres_q.size());
    end
`ifndef FETCH_TIMEOUT_EN
    checks++;
    if (FetchErr !== 1'b0) begin
      errors++;
      $display("FAIL err_tied: FetchErr=%b required 0", FetchErr);
    end
`endif
  endtask

`ifdef FETCH_TIMEOUT_EN
  task automatic test_timeout;
    bit ok;
    int target;
    mem_on = 1'b0;
    req_q.push_back(32'h1C);
    req_q.push_back(32'h1C);
    pres_q.push_back(mk_pres(32'h1C));
    target = pres_cnt + 1;
    StallF = 1'b0;
    @(posedge clk); #1;
    @(negedge clk) StallF = 1'b1;
    for (int i = 1; i < 16; i++) begin
      @(posedge clk); #1;
      checks++;
      if (imem_req !== 1'b1 || FetchErr !== 1'b0) begin
        errors++;
        $display("FAIL tmo_wait[%0d]: req=%b err=%b required 1 0", i, imem_req, FetchErr);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (imem_req !== 1'b0 || FetchErr !== 1'b1) begin
      errors++;
      $display("FAIL tmo_retry: req=%b err=%b required 0 1", imem_req, FetchErr);
    end
    @(posedge clk); #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h1C || FetchErr !== 1'b1) begin
      errors++;
      $display("FAIL tmo_reissue: req=%b addr=%h err=%b required 1 0000001c 1", imem_req, imem_addr, FetchErr);
    end
    @(negedge clk);
    ack_delay = 0; mem_on = 1'b1;
    wait_pres(target, 1'b0, ok);
    checks++;
    if (!ok || FetchErr !== 1'b1 || req_q.size() != 0 || pres_q.size() != 0) begin
      errors++;
      $display("FAIL tmo_end: ok=%b err=%b left=%0d/%0d required 1 1 0/0",
               ok, FetchErr, req_q.size(), pres_q.size());
    end
  endtask
`endif

  initial begin
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_fetch();
    test_redirect_stall();
    test_wrap();
    test_back_to_back();
`ifdef FETCH_TIMEOUT_EN
    test_timeout();
`endif
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
